apu_cmd_rx: RTL and testbench

//  UART command receiver upstream of the chiptune synthesiser's register file.
//  - Oversamples the asynchronous serial input (8N1) and recovers bytes.
//  - Pairs each address byte with the following data byte.
//  - Emits single-cycle register-write strobes in the system clock domain.

---
 rtl/apu_cmd_rx_pkg.sv | 41 ++++
 rtl/apu_cmd_rx_uart_rx_core.sv | 164 ++++++++++++++++
 rtl/apu_cmd_rx.sv | 159 +++++++++++++++
 tb/tb_apu_cmd_rx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_cmd_rx_pkg.sv
//------------------------------------------------------------------------------
// apu_cmd_rx_pkg
// Shared definitions for the APU serial command receiver:
//   - RX (byte recovery) and pair (address/data) state encodings
//   - command byte layout: address flag bit and APU register address width
//   - oversampling ratio, mid-bit sample index and the divider computation
// No ports (package).
//------------------------------------------------------------------------------
`timescale 1ns/1ps

package apu_cmd_rx_pkg;

    // Command byte layout: [7] address flag, [6:5] must be zero, [4:0] address
    localparam int ADDR_FLAG  = 7;
    localparam int APU_ADDR_W = 5;

    // Each serial bit is split into OVERSAMPLE ticks; the bit value is taken
    // at SAMPLE_MID, which sits at the centre of the bit.
    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_MID = 4'd7;
    localparam logic [3:0] SAMPLE_END = 4'd15;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    typedef enum logic {
        PAIR_WAIT_ADDR = 1'b0,
        PAIR_WAIT_DATA = 1'b1
    } pair_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clkrate, input int baudrate);
        return (clkrate + (OVERSAMPLE / 2) * baudrate) / (OVERSAMPLE * baudrate);
    endfunction

endpackage

// File: rtl/apu_cmd_rx_uart_rx_core.sv
//------------------------------------------------------------------------------
// uart_rx_core
// 8N1 serial byte receiver with 16x oversampling.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial input, idle high, asynchronous to clk
//   rx_byte    out  last received byte (stable while byte_valid is high)
//   byte_valid out  one-clk strobe: a byte with a good stop bit was received
//   frame_err  out  one-clk strobe: false start or bad (low) stop bit
//   busy       out  high from start detect until the stop sample is taken
//   tick       out  oversample tick, only active while not idle
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_core #(
    parameter int CLKRATE  = 3_579_545,
    parameter int BAUDRATE = 9_600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy,
    output logic       tick
);
    import apu_cmd_rx_pkg::*;

    localparam int               DIV      = calc_div(CLKRATE, BAUDRATE);
    localparam int               DIV_W    = $clog2(DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    // Two-flop synchroniser plus one history flop for falling-edge detect.
    // All preset to 1 so reset never looks like a start bit.
    logic rx_meta_reg;
    logic rxs_reg;
    logic rxs_d_reg;

    rx_state_t        state_reg, state_next;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [3:0]       samp_cnt_reg, samp_next;
    logic [2:0]       bit_cnt_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             valid_reg, valid_next;
    logic             ferr_reg, ferr_next;

    logic start_det;
    logic mid_sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
            rxs_d_reg   <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rxs_reg     <= rx_meta_reg;
            rxs_d_reg   <= rxs_reg;
        end
    end

    assign start_det = (state_reg == RX_IDLE) && rxs_d_reg && !rxs_reg;

    // Divider is held at zero while idle, so it restarts from zero on the
    // clock that leaves IDLE: the first tick lands DIV clocks after start detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
        end else if ((state_reg == RX_IDLE) || tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    assign tick       = (state_reg != RX_IDLE) && (div_cnt_reg == DIV_LAST);
    assign mid_sample = tick && (samp_cnt_reg == SAMPLE_MID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RX_IDLE;
            samp_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            valid_reg    <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            samp_cnt_reg <= samp_next;
            bit_cnt_reg  <= bit_next;
            shift_reg    <= shift_next;
            valid_reg    <= valid_next;
            ferr_reg     <= ferr_next;
        end
    end

    // The sample counter free-runs modulo 16 from start detect, so every
    // bit (start, data, stop) is sampled at the same phase, index 7.
    always_comb begin
        state_next = state_reg;
        samp_next  = tick ? (samp_cnt_reg + 4'd1) : samp_cnt_reg;
        bit_next   = bit_cnt_reg;
        shift_next = shift_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                samp_next = '0;
                if (start_det) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (mid_sample) begin
                    if (rxs_reg) begin
                        // Line came back high before mid-bit: a glitch.
                        ferr_next  = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        bit_next   = '0;
                        state_next = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (mid_sample) begin
                    shift_next = {rxs_reg, shift_reg[7:1]};  // LSB first
                    bit_next   = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (mid_sample) begin
                    if (rxs_reg) begin
                        valid_next = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // Wait out a held-low line so it is not taken as a new start.
                if (rxs_reg) begin
                    state_next = RX_IDLE;
                end
            end
            default: begin
                state_next = RX_IDLE;
            end
        endcase
    end

    assign rx_byte    = shift_reg;
    assign byte_valid = valid_reg;
    assign frame_err  = ferr_reg;
    assign busy       = (state_reg == RX_START) || (state_reg == RX_DATA) ||
                        (state_reg == RX_STOP);

endmodule

// File: rtl/apu_cmd_rx.sv
//------------------------------------------------------------------------------
// apu_cmd_rx
// UART command receiver for the chiptune APU register file. Received bytes
// are paired as (address, data) and turned into single-cycle register writes.
//   clk        in   system clock (same as the chiptune core)
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial data, 8N1, idle high, asynchronous
//   reg_we     out  one-clk register write strobe
//   reg_addr   out  register address, updated with reg_we and held
//   reg_data   out  register data, updated with reg_we and held
//   frame_err  out  one-clk pulse on false start or bad stop bit
//   busy       out  high while a frame is being received
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module apu_cmd_rx
    import apu_cmd_rx_pkg::*;
#(
    parameter int CLKRATE  = 3_579_545,
    parameter int BAUDRATE = 9_600,
    parameter int TIMEOUT  = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic                  reg_we,
    output logic [APU_ADDR_W-1:0] reg_addr,
    output logic [7:0]            reg_data,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int               DIV      = calc_div(CLKRATE, BAUDRATE);
    localparam int               DIV_W    = $clog2(DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       core_ferr;
    logic       core_busy;
    logic       core_tick;

    uart_rx_core #(
        .CLKRATE  (CLKRATE),
        .BAUDRATE (BAUDRATE)
    ) u_rx_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (core_ferr),
        .busy       (core_busy),
        .tick       (core_tick)
    );

    // The receiver only ticks while a frame is in flight, but the pairing
    // timeout must also advance while the line sits idle. A local divider
    // supplies ticks in that case. While the pair FSM waits for data the
    // receiver is never in BREAK (a frame error abandons the pair), so the
    // two sources never overlap.
    logic [DIV_W-1:0] idle_div_reg;
    logic             idle_tick;
    logic             bt_tick;

    assign idle_tick = !core_busy && (idle_div_reg == DIV_LAST);
    assign bt_tick   = core_busy ? core_tick : idle_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_div_reg <= '0;
        end else if (core_busy || idle_tick) begin
            idle_div_reg <= '0;
        end else begin
            idle_div_reg <= idle_div_reg + 1'b1;
        end
    end

    pair_state_t           pair_reg, pair_next;
    logic [APU_ADDR_W-1:0] addr_reg, addr_next;
    logic [TMO_W-1:0]      tmo_cnt_reg, tmo_cnt_next;
    logic [3:0]            tmo_samp_reg, tmo_samp_next;
    logic                  we_reg, we_next;
    logic [APU_ADDR_W-1:0] out_addr_reg, out_addr_next;
    logic [7:0]            out_data_reg, out_data_next;

    logic is_addr_byte;
    assign is_addr_byte = rx_byte[ADDR_FLAG] &&
                          (rx_byte[ADDR_FLAG-1:APU_ADDR_W] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_reg     <= PAIR_WAIT_ADDR;
            addr_reg     <= '0;
            tmo_cnt_reg  <= '0;
            tmo_samp_reg <= '0;
            we_reg       <= 1'b0;
            out_addr_reg <= '0;
            out_data_reg <= '0;
        end else begin
            pair_reg     <= pair_next;
            addr_reg     <= addr_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            tmo_samp_reg <= tmo_samp_next;
            we_reg       <= we_next;
            out_addr_reg <= out_addr_next;
            out_data_reg <= out_data_next;
        end
    end

    always_comb begin
        pair_next     = pair_reg;
        addr_next     = addr_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        tmo_samp_next = tmo_samp_reg;
        we_next       = 1'b0;
        out_addr_next = out_addr_reg;
        out_data_next = out_data_reg;
        case (pair_reg)
            PAIR_WAIT_ADDR: begin
                // Anything that is not a well-formed address byte is ignored.
                if (byte_valid && is_addr_byte) begin
                    addr_next     = rx_byte[APU_ADDR_W-1:0];
                    tmo_cnt_next  = '0;
                    tmo_samp_next = '0;
                    pair_next     = PAIR_WAIT_DATA;
                end
            end
            PAIR_WAIT_DATA: begin
                if (byte_valid) begin
                    // Data byte is taken verbatim, including bit 7.
                    we_next       = 1'b1;
                    out_addr_next = addr_reg;
                    out_data_next = rx_byte;
                    pair_next     = PAIR_WAIT_ADDR;
                end else if (core_ferr || (tmo_cnt_reg == TMO_MAX)) begin
                    pair_next = PAIR_WAIT_ADDR;
                end else if (bt_tick) begin
                    tmo_samp_next = tmo_samp_reg + 4'd1;
                    if ((tmo_samp_reg == SAMPLE_END) && (tmo_cnt_reg != TMO_MAX)) begin
                        tmo_cnt_next = tmo_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                pair_next = PAIR_WAIT_ADDR;
            end
        endcase
    end

    assign reg_we    = we_reg;
    assign reg_addr  = out_addr_reg;
    assign reg_data  = out_data_reg;
    assign frame_err = core_ferr;
    assign busy      = core_busy;

endmodule

// File: tb/tb_apu_cmd_rx.sv
`timescale 1ns/1ps

module tb_apu_cmd_rx;

    // Reduced clock rate keeps simulation short: DIV = 4, 64 clk per bit.
    localparam int  CLKRATE  = 614_400;
    localparam int  BAUDRATE = 9_600;
    localparam int  TIMEOUT  = 20;
    localparam int  DIV      = (CLKRATE + 8 * BAUDRATE) / (16 * BAUDRATE);
    localparam int  BIT_CLK  = 16 * DIV;
    localparam real CLK_NS   = 10.0;
    localparam real BIT_NS   = BIT_CLK * CLK_NS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       reg_we;
    logic [4:0] reg_addr;
    logic [7:0] reg_data;
    logic       frame_err;
    logic       busy;

    apu_cmd_rx #(
        .CLKRATE  (CLKRATE),
        .BAUDRATE (BAUDRATE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #(CLK_NS / 2.0) clk = ~clk;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        int         lat;
    } wr_t;

    // ---------------- observation (monitor) ----------------
    wr_t  obs_q[$];
    int   cyc = 0;
    int   last_fall = 0;
    int   ferr_cnt = 0;
    int   busy_rise_cnt = 0;
    logic busy_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        busy_d <= busy;
        if (busy_d && !busy) last_fall <= cyc;
        if (!busy_d && busy) busy_rise_cnt <= busy_rise_cnt + 1;
        if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (reg_we === 1'b1) obs_q.push_back('{a: reg_addr, d: reg_data, lat: cyc - last_fall});
    end

    // ---------------- reference model ----------------
    // Works on whole bytes and elapsed bit-times: a data byte pairs with a
    // pending address if fewer than TIMEOUT bit-times passed since the address.
    wr_t        exp_q[$];
    int         exp_ferr = 0;
    bit         pend = 1'b0;
    logic [4:0] pend_addr = '0;
    int         pend_bits = 0;

    int n_cmp = 0;
    int n_bad = 0;
    int obs_rd = 0;
    int exp_rd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic model_frame(input logic [7:0] b);
        if (pend) pend_bits += 10;
        if (pend && pend_bits < TIMEOUT) begin
            exp_q.push_back('{a: pend_addr, d: b, lat: 1});
            pend = 1'b0;
        end else begin
            pend = 1'b0;
            if (b[7] && b[6:5] == 2'b00) begin
                pend      = 1'b1;
                pend_addr = b[4:0];
                pend_bits = 0;
            end
        end
    endtask

    task automatic model_ferr();
        exp_ferr++;
        pend = 1'b0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_frame(input logic [7:0] b, input int stop_low, input real bt);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bt);
        end
        if (stop_low > 0) begin
            rx = 1'b0;
            #(bt * stop_low);
        end
        rx = 1'b1;
        #(bt);
    endtask

    task automatic idle(input int bits, input real bt);
        rx = 1'b1;
        #(bt * bits);
        if (pend) pend_bits += bits;
    endtask

    task automatic send(input logic [7:0] b, input int gap, input real bt);
        drive_frame(b, 0, bt);
        model_frame(b);
        idle(gap, bt);
    endtask

    task automatic check_scn(input string tag);
        idle(2, BIT_NS);
        @(negedge clk);
        chk({tag, " write_count"}, obs_q.size(), exp_q.size());
        while (obs_rd < obs_q.size() && exp_rd < exp_q.size()) begin
            chk({tag, " addr"}, obs_q[obs_rd].a, exp_q[exp_rd].a);
            chk({tag, " data"}, obs_q[obs_rd].d, exp_q[exp_rd].d);
            chk({tag, " we_latency"}, obs_q[obs_rd].lat, exp_q[exp_rd].lat);
            obs_rd++;
            exp_rd++;
        end
        obs_rd = obs_q.size();
        exp_rd = exp_q.size();
        chk({tag, " frame_err_count"}, ferr_cnt, exp_ferr);
        chk({tag, " busy_idle"}, busy, 1'b0);
        chk({tag, " we_idle"}, reg_we, 1'b0);
        if (exp_q.size() > 0) begin
            chk({tag, " addr_hold"}, reg_addr, exp_q[exp_q.size() - 1].a);
            chk({tag, " data_hold"}, reg_data, exp_q[exp_q.size() - 1].d);
        end
        $display("scenario %s: writes=%0d frame_errs=%0d checks=%0d", tag, obs_q.size(), ferr_cnt, n_cmp);
    endtask

    initial begin
        #(200_000 * CLK_NS);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int rises;
        logic [7:0] rb;
        int gap;

        rx    = 1'b1;
        rst_n = 1'b0;
        #(2 * CLK_NS);
        chk("reset reg_we", reg_we, 1'b0);
        chk("reset reg_addr", reg_addr, 5'd0);
        chk("reset reg_data", reg_data, 8'd0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset busy", busy, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(2, BIT_NS);

        // 1: basic address/data pair
        send(8'h83, 2, BIT_NS);
        send(8'h5A, 2, BIT_NS);
        check_scn("s1");

        // 2: data byte with bit 7 set is still data
        send(8'h95, 1, BIT_NS);
        send(8'h80, 2, BIT_NS);
        check_scn("s2");

        // 3: non-address bytes are dropped
        send(8'h05, 1, BIT_NS);
        send(8'hE1, 2, BIT_NS);
        check_scn("s3");

        // 4: stop bit held low for 3 bit-times, then a good pair
        drive_frame(8'h82, 3, BIT_NS);
        model_ferr();
        idle(2, BIT_NS);
        send(8'h82, 1, BIT_NS);
        send(8'h11, 2, BIT_NS);
        check_scn("s4");

        // 5: pair timeout, then a lone data byte
        send(8'h81, 21, BIT_NS);
        send(8'h22, 2, BIT_NS);
        check_scn("s5a");
        send(8'h22, 2, BIT_NS);
        check_scn("s5b");

        // 6a: short glitch while an address is pending
        send(8'h9F, 1, BIT_NS);
        rises = busy_rise_cnt;
        rx = 1'b0;
        #((BIT_CLK / 4) * CLK_NS);
        rx = 1'b1;
        model_ferr();
        idle(2, BIT_NS);
        @(negedge clk);
        chk("s6a busy_pulse", busy_rise_cnt - rises, 1);
        send(8'h44, 2, BIT_NS);
        check_scn("s6a");

        // 6b: reset in the middle of a frame while an address is pending
        send(8'h9F, 1, BIT_NS);
        rx = 1'b0;
        #(BIT_NS);
        rx = 1'b1;
        #(BIT_NS);
        rx = 1'b0;
        #(BIT_NS * 1.5);
        @(negedge clk);
        chk("s6b busy_mid_frame", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("s6b rst reg_we", reg_we, 1'b0);
        chk("s6b rst reg_addr", reg_addr, 5'd0);
        chk("s6b rst reg_data", reg_data, 8'd0);
        chk("s6b rst frame_err", frame_err, 1'b0);
        chk("s6b rst busy", busy, 1'b0);
        pend = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle(2, BIT_NS);
        send(8'h84, 2, BIT_NS);
        send(8'h33, 2, BIT_NS);
        check_scn("s6b");

        // Baud skew on scenario 1
        send(8'h83, 2, BIT_NS * 1.02);
        send(8'h5A, 2, BIT_NS * 1.02);
        check_scn("skew_slow");
        send(8'h83, 2, BIT_NS * 0.98);
        send(8'h5A, 2, BIT_NS * 0.98);
        check_scn("skew_fast");

        // Random byte stream; gaps kept clear of the timeout boundary
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) rb = {3'b100, 5'($urandom)};
            else rb = 8'($urandom);
            gap = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 4));
            send(rb, gap, BIT_NS);
        end
        idle(25, BIT_NS);
        check_scn("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
